// File: rtl/fetch_stage_if.sv
// Instruction-memory request port of the fetch stage.
// req/addr go out, rdata/ready come back; a request stays up until ready.
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        ready;

   modport master (
      output req,
      output addr,
      input  rdata,
      input  ready
   );

   modport slave (
      input  req,
      input  addr,
      output rdata,
      output ready
   );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns pc_F, buffers words across stalls.
// Optional FETCH_PERF_CNT_EN adds fetch_wait_cnt / redirect_cnt ports.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_F,
   input  logic        stall_D,
   input  logic        pc_src_D,
   input  logic [31:0] pc_branch_D,
   input  logic        jump_D,
   input  logic [31:0] jump_target_D,
   input  logic        jr_D,
   input  logic [31:0] jr_target_D,
   fetch_stage_if.master imem,
   output logic [31:0] instr_D,
   output logic [31:0] pc_plus4_D,
   output logic        valid_D,
   output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_wait_cnt,
   output logic [31:0] redirect_cnt
`endif
);

   typedef enum logic [1:0] {
      FETCH,
      HELD,
      DROP
   } state_t;

   state_t      state;
   logic [31:0] pc_F;
   logic [31:0] pend_pc;
   logic [31:0] hold_instr;
   logic [31:0] pc_plus4;
   logic [31:0] raw_target;
   logic [31:0] target;
   logic        redirect;

   assign redirect = !stall_D & (pc_src_D | jump_D | jr_D);
   assign pc_plus4 = pc_F + 32'd4;

   always_comb begin
      raw_target = pc_branch_D;
      if (jr_D)
         raw_target = jr_target_D;
      else if (jump_D)
         raw_target = jump_target_D;
   end

   assign target = {raw_target[31:2], 2'b00};

   // HELD parks the word locally, so the memory port is idle there.
   assign imem.req  = rst_n & (state != HELD);
   assign imem.addr = pc_F;

   assign fetch_busy = rst_n &
      (((state == FETCH) & !imem.ready) | (state == DROP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         pc_F       <= RESET_PC;
         pend_pc    <= 32'd0;
         hold_instr <= 32'd0;
         instr_D    <= 32'd0;
         pc_plus4_D <= 32'd0;
         valid_D    <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem.ready) begin
                  if (redirect) begin
                     instr_D <= 32'd0;
                     valid_D <= 1'b0;
                     pc_F    <= target;
                  end else if (!stall_F && !stall_D) begin
                     instr_D    <= imem.rdata;
                     pc_plus4_D <= pc_plus4;
                     valid_D    <= 1'b1;
                     pc_F       <= pc_plus4;
                  end else begin
                     hold_instr <= imem.rdata;
                     state      <= HELD;
                  end
               end else if (redirect) begin
                  // The old request cannot be withdrawn; drain it first.
                  pend_pc <= target;
                  instr_D <= 32'd0;
                  valid_D <= 1'b0;
                  state   <= DROP;
               end else if (!stall_D) begin
                  instr_D <= 32'd0;
                  valid_D <= 1'b0;
               end
            end
            HELD: begin
               if (redirect) begin
                  instr_D <= 32'd0;
                  valid_D <= 1'b0;
                  pc_F    <= target;
                  state   <= FETCH;
               end else if (!stall_F && !stall_D) begin
                  instr_D    <= hold_instr;
                  pc_plus4_D <= pc_plus4;
                  valid_D    <= 1'b1;
                  pc_F       <= pc_plus4;
                  state      <= FETCH;
               end
            end
            DROP: begin
               if (!stall_D) begin
                  instr_D <= 32'd0;
                  valid_D <= 1'b0;
               end
               if (redirect)
                  pend_pc <= target;
               if (imem.ready) begin
                  pc_F  <= redirect ? target : pend_pc;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_wait_cnt <= 32'd0;
         redirect_cnt   <= 32'd0;
      end else begin
         if (fetch_busy && fetch_wait_cnt != 32'hFFFF_FFFF)
            fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
         if (redirect && redirect_cnt != 32'hFFFF_FFFF)
            redirect_cnt <= redirect_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a
// randomized run checked against a program-order stream model.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        stall_F;
   logic        stall_D;
   logic        pc_src_D;
   logic [31:0] pc_branch_D;
   logic        jump_D;
   logic [31:0] jump_target_D;
   logic        jr_D;
   logic [31:0] jr_target_D;
   logic [31:0] instr_D;
   logic [31:0] pc_plus4_D;
   logic        valid_D;
   logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_wait_cnt;
   logic [31:0] redirect_cnt;
`endif

   int checks;
   int errors;

   fetch_stage_if imem ();

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_F       (stall_F),
      .stall_D       (stall_D),
      .pc_src_D      (pc_src_D),
      .pc_branch_D   (pc_branch_D),
      .jump_D        (jump_D),
      .jump_target_D (jump_target_D),
      .jr_D          (jr_D),
      .jr_target_D   (jr_target_D),
      .imem          (imem.master),
      .instr_D       (instr_D),
      .pc_plus4_D    (pc_plus4_D),
      .valid_D       (valid_D),
      .fetch_busy    (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_wait_cnt(fetch_wait_cnt),
      .redirect_cnt  (redirect_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign imem.rdata = imem.ready ? mem(imem.addr) : 32'hDEAD_BEEF;

   task automatic set_in(input bit st, input bit br, input bit jp,
                         input bit jrr, input bit rdy);
      stall_F    = st;
      stall_D    = st;
      pc_src_D   = br;
      jump_D     = jp;
      jr_D       = jrr;
      imem.ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 1);
      #23;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 1);
      #13;
      checks++;
      if (imem.req !== 1'b0 || valid_D !== 1'b0 || instr_D !== 32'd0 ||
          pc_plus4_D !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h, want 0/0/0/0",
                  imem.req, valid_D, instr_D, pc_plus4_D);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_release: req=%b addr=%h, want 1/%h",
                  imem.req, imem.addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (valid_D !== 1'b1 || pc_plus4_D !== RESET_PC + 4 * k ||
             instr_D !== mem(RESET_PC + 4 * (k - 1)) ||
             imem.addr !== RESET_PC + 4 * k) begin
            errors++;
            $display("FAIL stream_%0d: v=%b pc4=%h instr=%h addr=%h, want 1/%h/%h/%h",
                     k, valid_D, pc_plus4_D, instr_D, imem.addr,
                     RESET_PC + 4 * k, mem(RESET_PC + 4 * (k - 1)),
                     RESET_PC + 4 * k);
         end
      end
   endtask

   task automatic go_to(input logic [31:0] t);
      set_in(0, 0, 1, 0, 1);
      jump_target_D = t;
      step();
      set_in(0, 0, 0, 0, 1);
   endtask

   task automatic test_wait();
      go_to(32'h10);
      set_in(0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (imem.addr !== 32'h10 || imem.req !== 1'b1 ||
             fetch_busy !== 1'b1 || valid_D !== 1'b0) begin
            errors++;
            $display("FAIL wait_%0d: addr=%h req=%b busy=%b v=%b, want 10/1/1/0",
                     k, imem.addr, imem.req, fetch_busy, valid_D);
         end
      end
      imem.ready = 1'b1;
      step();
      checks++;
      if (valid_D !== 1'b1 || instr_D !== mem(32'h10) ||
          pc_plus4_D !== 32'h14 || imem.addr !== 32'h14) begin
         errors++;
         $display("FAIL wait_done: v=%b instr=%h pc4=%h addr=%h, want 1/%h/14/14",
                  valid_D, instr_D, pc_plus4_D, imem.addr, mem(32'h10));
      end
   endtask

   task automatic test_held();
      go_to(32'h1C);
      step();
      set_in(1, 0, 0, 0, 1);
      step();
      set_in(1, 1, 0, 0, 0);
      pc_branch_D = 32'h400;
      for (int k = 0; k < 2; k++) begin
         if (k == 1) step();
         checks++;
         if (imem.req !== 1'b0 || valid_D !== 1'b1 ||
             instr_D !== mem(32'h1C) || pc_plus4_D !== 32'h20) begin
            errors++;
            $display("FAIL held_%0d: req=%b v=%b instr=%h pc4=%h, want 0/1/%h/20",
                     k, imem.req, valid_D, instr_D, pc_plus4_D, mem(32'h1C));
         end
      end
      step();
      set_in(0, 0, 0, 0, 1);
      step();
      checks++;
      if (valid_D !== 1'b1 || instr_D !== mem(32'h20) ||
          pc_plus4_D !== 32'h24 || imem.addr !== 32'h24 ||
          imem.req !== 1'b1) begin
         errors++;
         $display("FAIL held_release: v=%b instr=%h pc4=%h addr=%h req=%b, want 1/%h/24/24/1",
                  valid_D, instr_D, pc_plus4_D, imem.addr, imem.req,
                  mem(32'h20));
      end
   endtask

   task automatic test_branch();
      set_in(0, 1, 0, 0, 1);
      pc_branch_D = 32'h102;
      step();
      set_in(0, 0, 0, 0, 1);
      checks++;
      if (imem.addr !== 32'h100 || valid_D !== 1'b0) begin
         errors++;
         $display("FAIL branch: addr=%h v=%b, want 100/0", imem.addr, valid_D);
      end
      step();
      checks++;
      if (valid_D !== 1'b1 || instr_D !== mem(32'h100) ||
          pc_plus4_D !== 32'h104) begin
         errors++;
         $display("FAIL branch_target: v=%b instr=%h pc4=%h, want 1/%h/104",
                  valid_D, instr_D, pc_plus4_D, mem(32'h100));
      end
   endtask

   task automatic test_drop();
      logic [31:0] old;
      old = imem.addr;
      set_in(0, 0, 1, 1, 0);
      jr_target_D   = 32'h200;
      jump_target_D = 32'h300;
      step();
      set_in(0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         if (k == 1) step();
         checks++;
         if (imem.addr !== old || imem.req !== 1'b1 ||
             fetch_busy !== 1'b1 || valid_D !== 1'b0) begin
            errors++;
            $display("FAIL drop_%0d: addr=%h req=%b busy=%b v=%b, want %h/1/1/0",
                     k, imem.addr, imem.req, fetch_busy, valid_D, old);
         end
      end
      imem.ready = 1'b1;
      step();
      checks++;
      if (imem.addr !== 32'h200 || valid_D !== 1'b0) begin
         errors++;
         $display("FAIL drop_redirect: addr=%h v=%b, want 200/0",
                  imem.addr, valid_D);
      end
      step();
      checks++;
      if (valid_D !== 1'b1 || instr_D !== mem(32'h200) ||
          pc_plus4_D !== 32'h204) begin
         errors++;
         $display("FAIL drop_target: v=%b instr=%h pc4=%h, want 1/%h/204",
                  valid_D, instr_D, pc_plus4_D, mem(32'h200));
      end
   endtask

   task automatic test_reset_mid_drop();
      set_in(0, 0, 1, 0, 0);
      jump_target_D = 32'h300;
      step();
      set_in(0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem.req !== 1'b0 || valid_D !== 1'b0 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_drop: req=%b v=%b busy=%b, want 0/0/0",
                  imem.req, valid_D, fetch_busy);
      end
      imem.ready = 1'b1;
      step();
      imem.ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem.addr !== RESET_PC || imem.req !== 1'b1) begin
         errors++;
         $display("FAIL rst_release_addr: addr=%h req=%b, want %h/1",
                  imem.addr, imem.req, RESET_PC);
      end
      imem.ready = 1'b1;
      step();
      checks++;
      if (valid_D !== 1'b1 || instr_D !== mem(RESET_PC)) begin
         errors++;
         $display("FAIL rst_first_instr: v=%b instr=%h, want 1/%h",
                  valid_D, instr_D, mem(RESET_PC));
      end
   endtask

   task automatic test_wrap();
      go_to(32'hFFFF_FFFF);
      checks++;
      if (imem.addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_align: addr=%h, want fffffffc", imem.addr);
      end
      step();
      checks++;
      if (imem.addr !== 32'd0 || pc_plus4_D !== 32'd0 ||
          instr_D !== mem(32'hFFFF_FFFC) || valid_D !== 1'b1) begin
         errors++;
         $display("FAIL wrap: addr=%h pc4=%h instr=%h v=%b, want 0/0/%h/1",
                  imem.addr, pc_plus4_D, instr_D, valid_D,
                  mem(32'hFFFF_FFFC));
      end
   endtask

   // Model: delivered instructions follow program order from the last
   // applied redirect; stalls only delay delivery, never lose or repeat it.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] t;
      logic [31:0] p_instr, p_pc4, p_addr;
      logic        p_valid, p_req, p_rdy, p_stall, p_redir;
      int          delivered;
      int          redirects;
      do_reset();
      exp_pc    = RESET_PC;
      delivered = 0;
      redirects = 0;
      for (int c = 0; c < 3000; c++) begin
         set_in($urandom_range(3) == 0, $urandom_range(9) == 0,
                $urandom_range(11) == 0, $urandom_range(13) == 0,
                $urandom_range(9) < 7);
         pc_branch_D   = $urandom;
         jump_target_D = $urandom;
         jr_target_D   = $urandom;
         #1;
         p_instr = instr_D;
         p_pc4   = pc_plus4_D;
         p_valid = valid_D;
         p_req   = imem.req;
         p_addr  = imem.addr;
         p_rdy   = imem.ready;
         p_stall = stall_D;
         p_redir = !stall_D && (pc_src_D || jump_D || jr_D);
         t = jr_D ? jr_target_D : (jump_D ? jump_target_D : pc_branch_D);
         t[1:0] = 2'b00;
         step();
         if (p_stall) begin
            checks++;
            if (instr_D !== p_instr || pc_plus4_D !== p_pc4 ||
                valid_D !== p_valid) begin
               errors++;
               $display("FAIL rnd_freeze c=%0d: %h/%h/%b, want %h/%h/%b",
                        c, instr_D, pc_plus4_D, valid_D,
                        p_instr, p_pc4, p_valid);
            end
         end else if (p_redir) begin
            redirects++;
            exp_pc = t;
            checks++;
            if (valid_D !== 1'b0 || instr_D !== 32'd0) begin
               errors++;
               $display("FAIL rnd_bubble c=%0d: v=%b instr=%h, want 0/0",
                        c, valid_D, instr_D);
            end
         end else if (valid_D === 1'b1) begin
            delivered++;
            checks++;
            if (pc_plus4_D !== exp_pc + 32'd4 || instr_D !== mem(exp_pc)) begin
               errors++;
               $display("FAIL rnd_order c=%0d: pc4=%h instr=%h, want %h/%h",
                        c, pc_plus4_D, instr_D, exp_pc + 32'd4, mem(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
         if (p_req && !p_rdy) begin
            checks++;
            if (imem.req !== 1'b1 || imem.addr !== p_addr) begin
               errors++;
               $display("FAIL rnd_addr_stable c=%0d: req=%b addr=%h, want 1/%h",
                        c, imem.req, imem.addr, p_addr);
            end
         end
         checks++;
         if (imem.addr[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL rnd_align c=%0d: addr=%h", c, imem.addr);
         end
      end
      checks++;
      if (delivered < 200) begin
         errors++;
         $display("FAIL rnd_progress: delivered=%0d, want >=200", delivered);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (redirect_cnt !== redirects) begin
         errors++;
         $display("FAIL rnd_redirect_cnt: %0d, want %0d",
                  redirect_cnt, redirects);
      end
`endif
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      pc_branch_D   = 32'd0;
      jump_target_D = 32'd0;
      jr_target_D   = 32'd0;
      set_in(0, 0, 0, 0, 0);
      test_reset();
      test_stream();
      test_wait();
      test_held();
      test_branch();
      test_drop();
      test_reset_mid_drop();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
